// File: rtl/apb_master.sv
// apb_master: APB requester stage. Takes single read/write commands on a
// valid/ready port, runs them as IDLE -> SETUP -> ACCESS on the APB bus and
// returns read data and status on a one-cycle response strobe. Commands can
// chain back-to-back straight from ACCESS into SETUP.
// Optional ACCESS-phase timeout: define APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  w_abort;

  // The counter is 10 bits wide, so reject timeouts it cannot represent.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be in 1..1023");
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);

  logic [9:0] r_count;
  logic       r_rsp_err;

  // Abort in the TIMEOUT_CYCLES-th ACCESS cycle unless PREADY arrives then.
  assign w_abort = (r_state == ST_ACCESS) && !PREADY && (r_count == TO_LAST);

  // Wait-state counter and the sticky error flag that goes with each response.
  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      r_count   <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: ;
        ST_SETUP: r_count <= '0;
        ST_ACCESS: begin
          if (!PREADY) r_count <= r_count + 10'd1;
          if (w_abort) r_rsp_err <= 1'b1;
          else if (PREADY) r_rsp_err <= 1'b0;
        end
        default: r_rsp_err <= 1'b0;
      endcase
    end
  end

  assign rsp_err = r_rsp_err;
`else
  assign w_abort = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // A command is taken in IDLE, or in ACCESS at a completion that is not an abort.
  assign req_ready = PRESET &&
                     ((r_state == ST_IDLE) ||
                      ((r_state == ST_ACCESS) && PREADY && !w_abort));

  // Main sequencer: state, APB signals and the response strobe are all registered.
  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      r_state     <= ST_IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          if (req_valid) begin
            r_pwrite <= req_write;
            r_paddr  <= req_addr;
            r_pwdata <= req_wdata;
            r_psel   <= 1'b1;
            r_state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_psel    <= 1'b1;
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (w_abort) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_state     <= ST_IDLE;
          end else if (PREADY) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
            r_penable   <= 1'b0;
            if (req_valid) begin
              r_pwrite <= req_write;
              r_paddr  <= req_addr;
              r_pwdata <= req_wdata;
              r_psel   <= 1'b1;
              r_state  <= ST_SETUP;
            end else begin
              r_psel  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_psel      <= 1'b0;
          r_penable   <= 1'b0;
          r_pwrite    <= 1'b0;
          r_paddr     <= '0;
          r_pwdata    <= '0;
          r_rsp_rdata <= '0;
        end
      endcase
    end
  end

  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester stage sitting directly upstream of the team's APB slave blocks.
- Accepts single read/write commands on a valid/ready request port and sequences them as IDLE -> SETUP -> ACCESS on the APB bus.
- Waits on PREADY and returns read data and status on a one-cycle response strobe.
- Supports back-to-back transfers without an intervening IDLE cycle.

Parameters:
- ADDR_WIDTH, 8, width of req_addr / PADDR.
- DATA_WIDTH, 32, width of all data buses.
- TIMEOUT_CYCLES, 16, ACCESS cycles allowed before abort; used only with APB_MASTER_TIMEOUT_EN; legal range 1..1023.

Ports:
- PCLK  input  1  clock; all logic on rising edge.
- PRESET  input  1  synchronous, active-low reset.
- req_valid  input  1  command present.
- req_ready  output  1  command accepted this cycle when high together with req_valid.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  transfer address.
- req_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  one-cycle pulse: transfer finished.
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and for aborts.
- rsp_err  output  1  1 = transfer aborted by timeout; valid with rsp_valid.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PADDR  output  ADDR_WIDTH  APB address.
- PWDATA  output  DATA_WIDTH  APB write data.
- PRDATA  input  DATA_WIDTH  APB read data from slave.
- PREADY  input  1  slave completion.

Behaviour:
- Reset:
  - Synchronous: while PRESET == 0 at a PCLK edge, state <= IDLE.
  - All registered outputs (PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err) <= 0.
  - Timeout counter <= 0.
  - Reset overrides any in-flight transfer; no response is issued for the aborted transfer.
- States: IDLE, SETUP, ACCESS; 2-bit encoding; the unused code returns to IDLE next cycle with all outputs 0.
- req_ready is combinational:
  - 1 in IDLE;
  - 1 in ACCESS when PREADY == 1 and the transfer is not being aborted;
  - 0 otherwise, and 0 during reset.
- IDLE:
  - PSEL = 0, PENABLE = 0.
  - On req_valid, capture req_write/req_addr/req_wdata into PWRITE/PADDR/PWDATA and go to SETUP.
- SETUP:
  - Exactly one cycle, with PSEL = 1, PENABLE = 0.
  - Unconditionally go to ACCESS.
- ACCESS:
  - PSEL = 1, PENABLE = 1; PADDR, PWDATA and PWRITE are held stable.
  - PREADY == 0: remain in ACCESS (wait state).
  - PREADY == 1, completion:
    - next cycle, rsp_valid = 1, rsp_err = 0;
    - rsp_rdata = PRDATA sampled at the completion edge for reads, 0 for writes.
  - Same-cycle req_valid at completion: capture the new command and go to SETUP (PSEL stays 1, PENABLE drops to 0).
  - No req_valid at completion: go to IDLE.
- rsp_valid is high for exactly one cycle per completed or aborted transfer. rsp_rdata and rsp_err hold their values until the next response.
- PADDR, PWDATA and PWRITE hold their last values in IDLE; they change only on command capture.
- Latency, zero wait states: acceptance at edge N -> SETUP in cycle N+1, ACCESS in cycle N+2, rsp_valid in cycle N+3. Each wait state adds one cycle.
- Throughput: back-to-back commands sustain one transfer per 2 cycles.
- Command inputs are ignored whenever req_ready == 0.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - The counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY == 0.
  - If PREADY is still 0 in the TIMEOUT_CYCLES-th ACCESS cycle, the transfer aborts:
    - next state is IDLE;
    - next cycle, rsp_valid = 1, rsp_err = 1, rsp_rdata = 0;
    - req_ready = 0 in the abort cycle.
  - If PREADY rises in that same cycle, completion wins and no error is flagged.
- Undefined:
  - No counter logic; ACCESS waits indefinitely.
  - rsp_err is tied to 0.

Test Plan:
- Write, then read, zero wait states:
  - write addr 0x10, data 0xDEADBEEF, then read 0x10;
  - APB phases are SETUP then ACCESS, each one cycle;
  - write response has rsp_rdata = 0; read response has rsp_rdata = 0xDEADBEEF, rsp_err = 0, 3 cycles after acceptance.
- Wait states: slave holds PREADY low for 3 ACCESS cycles on a read of 0x04 returning 0x12345678 -> PADDR stable throughout, rsp_valid 6 cycles after acceptance, rsp_rdata = 0x12345678.
- Back-to-back: req_valid held high with 4 writes to 0x00..0x03 -> PSEL never drops, PENABLE toggles 0,1,0,1,..., 4 rsp_valid pulses, 8 cycles from first SETUP to last completion.
- Reset mid-transfer: assert PRESET = 0 during ACCESS with PREADY low -> next edge PSEL = PENABLE = 0, rsp_valid = 0, state IDLE; a new read after release completes normally.
- Timeout (APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES = 4): PREADY held 0 -> exactly 4 ACCESS cycles, then rsp_valid = 1, rsp_err = 1, rsp_rdata = 0, PSEL = 0.
- Timeout edge case (APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES = 4): PREADY = 1 in the 4th ACCESS cycle -> rsp_err = 0.
